// File: rtl/rtc_bus_sequencer.sv
// Single-byte read/write sequencer for the RTC multiplexed address/data bus.
// Phases IDLE -> ADDR -> GAP -> DATA -> RECOV; every pin-facing output is registered.
module rtc_bus_sequencer #(
  parameter int unsigned T_ADDR = 4,
  parameter int unsigned T_GAP  = 2,
  parameter int unsigned T_DATA = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR
);

  localparam logic [7:0] LP_ADDR_M1 = 8'(T_ADDR - 1);
  localparam logic [7:0] LP_GAP_M1  = 8'(T_GAP - 1);
  localparam logic [7:0] LP_DATA_M1 = 8'(T_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_GAP   = 3'd2,
    S_DATA  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  state_t     r_state, w_next_state;
  logic [7:0] r_cnt, w_next_cnt, w_cnt_dec;
  logic       r_rw;
  logic [7:0] r_addr, r_wdata;
  logic       w_accept, w_last;
  logic       w_rw_nx;
  logic [7:0] w_addr_nx, w_wdata_nx;
  logic       w_ad, w_cs, w_rd, w_wr, w_oe;
  logic [7:0] w_bus;
  logic       r_ad, r_cs, r_rd, r_wr, r_oe, r_busy, r_done;
  logic [7:0] r_bus, r_rdata;

  assign w_accept   = (r_state == S_IDLE) && req;
  assign w_last     = (r_cnt == 8'd0);
  assign w_cnt_dec  = r_cnt - 8'd1;
  // Outputs are computed one cycle ahead, so the request fields must be visible on acceptance.
  assign w_rw_nx    = w_accept ? rw    : r_rw;
  assign w_addr_nx  = w_accept ? addr  : r_addr;
  assign w_wdata_nx = w_accept ? wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rw    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_rw    <= w_rw_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next_state = S_ADDR;
          w_next_cnt   = LP_ADDR_M1;
        end else begin
          w_next_state = S_IDLE;
          w_next_cnt   = 8'd0;
        end
      end
      S_ADDR: begin
        if (w_last) begin
          w_next_state = S_GAP;
          w_next_cnt   = LP_GAP_M1;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      S_GAP: begin
        if (w_last) begin
          w_next_state = S_DATA;
          w_next_cnt   = LP_DATA_M1;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_next_state = S_RECOV;
          w_next_cnt   = LP_GAP_M1;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      S_RECOV: begin
        if (w_last) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 8'd0;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_ad  = 1'b1;
    w_cs  = 1'b1;
    w_rd  = 1'b1;
    w_wr  = 1'b1;
    w_oe  = 1'b0;
    w_bus = 8'h00;
    case (w_next_state)
      S_IDLE: begin
        w_oe = 1'b0;
      end
      S_ADDR: begin
        w_ad  = 1'b0;
        w_cs  = 1'b0;
        w_wr  = 1'b0;
        w_oe  = 1'b1;
        w_bus = w_addr_nx;
      end
      S_GAP: begin
        w_oe  = 1'b1;
        w_bus = w_addr_nx;
      end
      S_DATA: begin
        w_cs = 1'b0;
        if (w_rw_nx) begin
          w_rd = 1'b0;
        end else begin
          w_wr  = 1'b0;
          w_oe  = 1'b1;
          w_bus = w_wdata_nx;
        end
      end
      S_RECOV: begin
        w_oe = 1'b0;
      end
      default: begin
        w_oe = 1'b0;
      end
    endcase
  end

  // Pin registers; rdata captures the pad on the final read DATA cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ad    <= 1'b1;
      r_cs    <= 1'b1;
      r_rd    <= 1'b1;
      r_wr    <= 1'b1;
      r_oe    <= 1'b0;
      r_bus   <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_ad   <= w_ad;
      r_cs   <= w_cs;
      r_rd   <= w_rd;
      r_wr   <= w_wr;
      r_oe   <= w_oe;
      r_bus  <= w_bus;
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (r_state == S_RECOV) && w_last;
      if ((r_state == S_DATA) && w_last && r_rw) begin
        r_rdata <= bus_in;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign AD      = r_ad;
  assign CS      = r_cs;
  assign RD      = r_rd;
  assign WR      = r_wr;
  assign bus_oe  = r_oe;
  assign bus_out = r_bus;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;

endmodule
